// File: rtl/rv32_pipeline_pkg.sv
// Shared pipeline types and helpers.
// Holds the data-memory FSM state and access-size encodings.
package rv32_pipeline_pkg;

    typedef enum logic {
        DMEM_IDLE,
        DMEM_RD_WAIT
    } dmem_state_t;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    function automatic logic [3:0] byte_enables(
        input logic [2:0] funct3,
        input logic [1:0] addr
    );
        logic [3:0] be;
        be = 4'b0000;
        case (funct3)
            MEM_B, MEM_BU: be = 4'b0001 << addr;
            MEM_H, MEM_HU: be = addr[1] ? 4'b1100 : 4'b0011;
            MEM_W:         be = 4'b1111;
            default:       be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/rv32_dmem_responder_if.sv
// MEM-stage data port between the pipeline and the data memory.
// master = pipeline MEM stage, slave = memory responder.
interface rv32_dmem_responder_if;

    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_read_data;
    logic        mem_stall;
    logic        mem_fault;
    logic [31:0] mem_fault_addr;

    modport master (
        output mem_address,
        output mem_write_data,
        output mem_write_en,
        output mem_read_en,
        output mem_funct3,
        input  mem_read_data,
        input  mem_stall,
        input  mem_fault,
        input  mem_fault_addr
    );

    modport slave (
        input  mem_address,
        input  mem_write_data,
        input  mem_write_en,
        input  mem_read_en,
        input  mem_funct3,
        output mem_read_data,
        output mem_stall,
        output mem_fault,
        output mem_fault_addr
    );

endinterface

// File: rtl/rv32_load_align.sv
// Load formatter: picks the addressed byte/half from a RAM word
// and sign- or zero-extends it to 32 bits.
module rv32_load_align
    import rv32_pipeline_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // lane selection
    always_comb begin
        byte_sel = word[8*lane +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
    end

    // extension by access type
    always_comb begin
        data = 32'd0;
        unique case (1'b1)
            (funct3 == MEM_B):  data = {{24{byte_sel[7]}}, byte_sel};
            (funct3 == MEM_BU): data = {24'd0, byte_sel};
            (funct3 == MEM_H):  data = {{16{half_sel[15]}}, half_sel};
            (funct3 == MEM_HU): data = {16'd0, half_sel};
            (funct3 == MEM_W):  data = word;
            default:            data = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv32_dmem_responder.sv
// Data-memory responder: byte-lane RAM, one-stall loads,
// and a sticky fault flag for illegal accesses.
module rv32_dmem_responder
    import rv32_pipeline_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32_dmem_responder_if.slave bus
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    dmem_state_t state, state_nx;

    logic [31:0] ram [DEPTH_WORDS];
    logic [31:0] ram_q;
    logic [1:0]  lane_q;
    logic [2:0]  f3_q;

    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          in_range;
    logic          f3_ok;
    logic          align_ok;
    logic          one_en;
    logic          any_en;
    logic          legal;
    logic          rd_issue;
    logic          wr_do;
    logic          fault_hit;
    logic          stall;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   fmt_data;

    // address decode and legality
    always_comb begin
        offset   = bus.mem_address - BASE_ADDR;
        idx      = offset[AW+1:2];
        lane     = offset[1:0];
        in_range = offset < SPAN;
        f3_ok    = (bus.mem_funct3 == MEM_B)  ||
                   (bus.mem_funct3 == MEM_H)  ||
                   (bus.mem_funct3 == MEM_W)  ||
                   (bus.mem_funct3 == MEM_BU) ||
                   (bus.mem_funct3 == MEM_HU);
        align_ok = 1'b1;
        if (bus.mem_funct3 == MEM_H || bus.mem_funct3 == MEM_HU)
            align_ok = ~bus.mem_address[0];
        else if (bus.mem_funct3 == MEM_W)
            align_ok = (bus.mem_address[1:0] == 2'b00);
        any_en = bus.mem_read_en | bus.mem_write_en;
        one_en = bus.mem_read_en ^ bus.mem_write_en;
        legal  = f3_ok & in_range & align_ok & one_en;
    end

    // store lane enables and replicated data
    always_comb begin
        be = byte_enables(bus.mem_funct3, lane);
        case (bus.mem_funct3[1:0])
            2'b00:   wdata = {4{bus.mem_write_data[7:0]}};
            2'b01:   wdata = {2{bus.mem_write_data[15:0]}};
            default: wdata = bus.mem_write_data;
        endcase
    end

    // FSM next state and per-cycle actions
    always_comb begin
        state_nx  = state;
        stall     = 1'b0;
        rd_issue  = 1'b0;
        wr_do     = 1'b0;
        fault_hit = 1'b0;
        unique case (state)
            DMEM_IDLE: begin
                if (any_en && !rst) begin
                    if (!legal) begin
                        fault_hit = 1'b1;
                    end else if (bus.mem_read_en) begin
                        stall    = 1'b1;
                        rd_issue = 1'b1;
                        state_nx = DMEM_RD_WAIT;
                    end else begin
                        wr_do = 1'b1;
                    end
                end
            end
            DMEM_RD_WAIT: begin
                state_nx = DMEM_IDLE;
            end
            default: state_nx = DMEM_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= DMEM_IDLE;
        else     state <= state_nx;
    end

    // byte-lane RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_do) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    // registered RAM read plus captured lane/size
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_q  <= 32'd0;
            lane_q <= 2'd0;
            f3_q   <= MEM_W;
        end else if (rd_issue) begin
            ram_q  <= ram[idx];
            lane_q <= lane;
            f3_q   <= bus.mem_funct3;
        end
    end

    // sticky fault flag; first faulting address is kept
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_fault      <= 1'b0;
            bus.mem_fault_addr <= 32'd0;
        end else if (fault_hit && !bus.mem_fault) begin
            bus.mem_fault      <= 1'b1;
            bus.mem_fault_addr <= bus.mem_address;
        end
    end

    rv32_load_align u_align (
        .word   (ram_q),
        .lane   (lane_q),
        .funct3 (f3_q),
        .data   (fmt_data)
    );

    // outputs: data only while the load completes
    always_comb begin
        bus.mem_stall     = stall;
        bus.mem_read_data = (state == DMEM_RD_WAIT) ? fmt_data : 32'd0;
    end

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Directed bench for the data-memory responder.
// Inputs change 1ns after the rising edge; outputs checked before the next one.
module tb_rv32_dmem_responder;
    import rv32_pipeline_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    rv32_dmem_responder_if bus ();

    rv32_dmem_responder #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mem_read_en    = 1'b0;
        bus.mem_write_en   = 1'b0;
        bus.mem_address    = 32'd0;
        bus.mem_write_data = 32'd0;
        bus.mem_funct3     = MEM_W;
    endtask

    task automatic store(input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] d);
        bus.mem_address    = a;
        bus.mem_write_data = d;
        bus.mem_funct3     = f3;
        bus.mem_write_en   = 1'b1;
        bus.mem_read_en    = 1'b0;
        #1;
        check("st_nostall", {31'd0, bus.mem_stall}, 32'd0);
        step();
        idle();
    endtask

    task automatic load(input string tag, input logic [31:0] a,
                        input logic [2:0] f3, input logic [31:0] exp);
        bus.mem_address  = a;
        bus.mem_funct3   = f3;
        bus.mem_read_en  = 1'b1;
        bus.mem_write_en = 1'b0;
        #1;
        check({tag, "_stall1"}, {31'd0, bus.mem_stall}, 32'd1);
        check({tag, "_rd0"}, bus.mem_read_data, 32'd0);
        step();
        check({tag, "_stall0"}, {31'd0, bus.mem_stall}, 32'd0);
        check(tag, bus.mem_read_data, exp);
        idle();
        step();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        check("rst_rd", bus.mem_read_data, 32'd0);
        check("rst_stall", {31'd0, bus.mem_stall}, 32'd0);
        check("rst_fault", {31'd0, bus.mem_fault}, 32'd0);
        check("rst_faddr", bus.mem_fault_addr, 32'd0);
        rst = 1'b0;
        step();

        store(32'h10, MEM_W, 32'hDEADBEEF);
        load("lw10", 32'h10, MEM_W, 32'hDEADBEEF);

        store(32'h20, MEM_W, 32'h0);
        store(32'h21, MEM_B, 32'h80);
        load("lb21", 32'h21, MEM_B, 32'hFFFFFF80);
        load("lbu21", 32'h21, MEM_BU, 32'h00000080);
        load("lw20", 32'h20, MEM_W, 32'h00008000);

        store(32'h30, MEM_W, 32'h0);
        store(32'h32, MEM_H, 32'h1234ABCD);
        load("lh32", 32'h32, MEM_H, 32'hFFFFABCD);
        load("lhu32", 32'h32, MEM_HU, 32'h0000ABCD);
        load("lhu30", 32'h30, MEM_HU, 32'h00000000);

        store(32'h0, MEM_W, 32'h5A5A5A5A);
        store(32'h14, MEM_W, 32'hCAFEF00D);

        bus.mem_address = 32'h06;
        bus.mem_funct3  = MEM_W;
        bus.mem_read_en = 1'b1;
        #1;
        check("mis_stall", {31'd0, bus.mem_stall}, 32'd0);
        check("mis_rd", bus.mem_read_data, 32'd0);
        step();
        idle();
        check("mis_fault", {31'd0, bus.mem_fault}, 32'd1);
        check("mis_faddr", bus.mem_fault_addr, 32'h06);
        store(32'h4001, MEM_W, 32'hFFFFFFFF);
        check("oor_faddr", bus.mem_fault_addr, 32'h06);
        load("lw0_keep", 32'h0, MEM_W, 32'h5A5A5A5A);

        bus.mem_address = 32'h10;
        bus.mem_funct3  = MEM_W;
        bus.mem_read_en = 1'b1;
        #1;
        check("b2b_stall_a", {31'd0, bus.mem_stall}, 32'd1);
        step();
        check("b2b_rd_a", bus.mem_read_data, 32'hDEADBEEF);
        check("b2b_wait_a", {31'd0, bus.mem_stall}, 32'd0);
        bus.mem_address = 32'h14;
        step();
        check("b2b_stall_b", {31'd0, bus.mem_stall}, 32'd1);
        step();
        check("b2b_rd_b", bus.mem_read_data, 32'hCAFEF00D);
        rst = 1'b1;
        step();
        check("rw_stall", {31'd0, bus.mem_stall}, 32'd0);
        check("rw_rd", bus.mem_read_data, 32'd0);
        check("rw_fault", {31'd0, bus.mem_fault}, 32'd0);
        check("rw_faddr", bus.mem_fault_addr, 32'd0);
        idle();
        rst = 1'b0;
        step();
        load("lw10_kept", 32'h10, MEM_W, 32'hDEADBEEF);

        store(32'h40, MEM_W, 32'h11223344);
        bus.mem_address    = 32'h40;
        bus.mem_write_data = 32'hFFFFFFFF;
        bus.mem_funct3     = MEM_W;
        bus.mem_read_en    = 1'b1;
        bus.mem_write_en   = 1'b1;
        #1;
        check("both_stall", {31'd0, bus.mem_stall}, 32'd0);
        step();
        idle();
        check("both_fault", {31'd0, bus.mem_fault}, 32'd1);
        check("both_faddr", bus.mem_fault_addr, 32'h40);
        load("lw40_keep", 32'h40, MEM_W, 32'h11223344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
